// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for an async FIFO: gates writes against FULL, keeps the
// binary/Gray write pointer, synchronises the read Gray pointer and derives status flags.
module fifo_wr_ptr_ctrl #(
  parameter int MEM_DEPTH    = 8,
  parameter int ADDR_WIDTH   = $clog2(MEM_DEPTH),
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = MEM_DEPTH - 2
) (
  input  logic                  W_CLK,
  input  logic                  W_RST_n,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   R_PTR_GRAY,
  input  logic                  OVF_CLR,
  output logic                  W_CLK_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   W_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PW = ADDR_WIDTH + 1;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
  localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_d, level_q;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;

  assign W_CLK_EN = W_INC & ~full_q;
  assign rq       = sync_q[SYNC_STAGES-1];

  always_comb begin
    rbin = '0;
    rbin[PW-1] = rq[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      rbin[i] = rbin[i+1] ^ rq[i];
    end
  end

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, W_CLK_EN};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    full_d  = (wgray_d == (rq ^ FULL_MASK));
    level_d = wbin_d - rbin;
    afull_d = (level_d >= AFULL_LVL);
    // A fresh overflow takes priority over a clear in the same cycle.
    ovf_d   = (W_INC & full_q) | (ovf_q & ~OVF_CLR);
  end

  always_ff @(posedge W_CLK or negedge W_RST_n) begin
    if (!W_RST_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= R_PTR_GRAY;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  always_ff @(posedge W_CLK or negedge W_RST_n) begin
    if (!W_RST_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign W_ADDR      = wbin_q[ADDR_WIDTH-1:0];
  assign W_PTR_GRAY  = wgray_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign W_LEVEL     = level_q;
  assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl with MEM_DEPTH=8, SYNC_STAGES=2, AFULL_THRESH=6.
module tb_fifo_wr_ptr_ctrl;

  logic       W_CLK;
  logic       W_RST_n;
  logic       W_INC;
  logic [3:0] R_PTR_GRAY;
  logic       OVF_CLR;
  logic       W_CLK_EN;
  logic [2:0] W_ADDR;
  logic [3:0] W_PTR_GRAY;
  logic       FULL;
  logic       ALMOST_FULL;
  logic [3:0] W_LEVEL;
  logic       OVERFLOW;

  int errors = 0;
  int checks = 0;

  fifo_wr_ptr_ctrl #(
    .MEM_DEPTH(8), .SYNC_STAGES(2), .AFULL_THRESH(6)
  ) dut (
    .W_CLK(W_CLK), .W_RST_n(W_RST_n), .W_INC(W_INC), .R_PTR_GRAY(R_PTR_GRAY),
    .OVF_CLR(OVF_CLR), .W_CLK_EN(W_CLK_EN), .W_ADDR(W_ADDR), .W_PTR_GRAY(W_PTR_GRAY),
    .FULL(FULL), .ALMOST_FULL(ALMOST_FULL), .W_LEVEL(W_LEVEL), .OVERFLOW(OVERFLOW)
  );

  initial begin
    W_CLK = 1'b0;
    forever #5 W_CLK = ~W_CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge W_CLK);
    #1;
  endtask

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  32'(W_ADDR), 32'd0);
    chk({tag, "_gray"},  32'(W_PTR_GRAY), 32'd0);
    chk({tag, "_full"},  32'(FULL), 32'd0);
    chk({tag, "_afull"}, 32'(ALMOST_FULL), 32'd0);
    chk({tag, "_level"}, 32'(W_LEVEL), 32'd0);
    chk({tag, "_ovf"},   32'(OVERFLOW), 32'd0);
  endtask

  task automatic do_reset();
    #2;
    W_RST_n = 1'b0;
    #1;
    chk_all_zero("reset");
    tick();
    #2;
    W_RST_n = 1'b1;
    tick();
  endtask

  initial begin
    W_RST_n    = 1'b0;
    W_INC      = 1'b0;
    R_PTR_GRAY = 4'b0000;
    OVF_CLR    = 1'b0;

    // 1: fill from empty
    do_reset();
    W_INC = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      chk("t1_addr", 32'(W_ADDR), 32'(i));
      chk("t1_en", 32'(W_CLK_EN), 32'd1);
      tick();
      chk("t1_level", 32'(W_LEVEL), 32'(i + 1));
      chk("t1_afull", 32'(ALMOST_FULL), 32'((i + 1) >= 6));
      chk("t1_full", 32'(FULL), 32'((i + 1) == 8));
      chk("t1_gray", 32'(W_PTR_GRAY), 32'(gray4(4'(i + 1))));
    end
    chk("t1_gray_final", 32'(W_PTR_GRAY), 32'b1100);

    // 2: writes while full are dropped and flag overflow
    for (int i = 0; i < 2; i++) begin
      chk("t2_en", 32'(W_CLK_EN), 32'd0);
      tick();
      chk("t2_addr", 32'(W_ADDR), 32'd0);
      chk("t2_ovf", 32'(OVERFLOW), 32'd1);
      chk("t2_full", 32'(FULL), 32'd1);
      chk("t2_level", 32'(W_LEVEL), 32'd8);
    end
    W_INC = 1'b0;
    tick();
    chk("t2_ovf_sticky", 32'(OVERFLOW), 32'd1);
    OVF_CLR = 1'b1;
    tick();
    chk("t2_ovf_clr", 32'(OVERFLOW), 32'd0);
    OVF_CLR = 1'b0;

    // 3: a read appears on the 3rd edge after R_PTR_GRAY changes
    R_PTR_GRAY = 4'b0001;
    tick();
    chk("t3_full_e1", 32'(FULL), 32'd1);
    chk("t3_level_e1", 32'(W_LEVEL), 32'd8);
    tick();
    chk("t3_full_e2", 32'(FULL), 32'd1);
    chk("t3_level_e2", 32'(W_LEVEL), 32'd8);
    tick();
    chk("t3_full_e3", 32'(FULL), 32'd0);
    chk("t3_level_e3", 32'(W_LEVEL), 32'd7);
    chk("t3_afull_e3", 32'(ALMOST_FULL), 32'd1);

    // 4: 20 writes with the reader two entries behind; level settles at 5
    R_PTR_GRAY = 4'b0000;
    do_reset();
    W_INC = 1'b1;
    for (int i = 0; i < 20; i++) begin
      R_PTR_GRAY = (i >= 2) ? gray4(4'(i - 2)) : 4'b0000;
      #1;
      chk("t4_addr", 32'(W_ADDR), 32'(i % 8));
      chk("t4_en", 32'(W_CLK_EN), 32'd1);
      tick();
      chk("t4_full", 32'(FULL), 32'd0);
      chk("t4_afull", 32'(ALMOST_FULL), 32'd0);
      chk("t4_level", 32'(W_LEVEL), (i >= 4) ? 32'd5 : 32'(i + 1));
      chk("t4_gray", 32'(W_PTR_GRAY), 32'(gray4(4'((i + 1) % 16))));
      if (i == 14) chk("t4_gray_1000", 32'(W_PTR_GRAY), 32'b1000);
      if (i == 15) chk("t4_gray_wrap", 32'(W_PTR_GRAY), 32'b0000);
    end

    // 5: asynchronous reset mid-burst
    W_INC = 1'b0;
    R_PTR_GRAY = 4'b0000;
    do_reset();
    W_INC = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("t5_addr_pre", 32'(W_ADDR), 32'd5);
    #2;
    W_RST_n = 1'b0;
    #1;
    chk_all_zero("t5_async");
    chk("t5_en_follows", 32'(W_CLK_EN), 32'd1);
    W_INC = 1'b0;
    tick();
    #2;
    W_RST_n = 1'b1;
    tick();
    W_INC = 1'b1;
    #1;
    chk("t5_first_addr", 32'(W_ADDR), 32'd0);
    tick();
    chk("t5_gray_after", 32'(W_PTR_GRAY), 32'b0001);
    chk("t5_addr_after", 32'(W_ADDR), 32'd1);

    // 6: overflow beats a simultaneous clear
    for (int i = 0; i < 7; i++) tick();
    chk("t6_full", 32'(FULL), 32'd1);
    tick();
    chk("t6_ovf_set", 32'(OVERFLOW), 32'd1);
    OVF_CLR = 1'b1;
    tick();
    chk("t6_ovf_wins", 32'(OVERFLOW), 32'd1);
    W_INC = 1'b0;
    tick();
    chk("t6_ovf_cleared", 32'(OVERFLOW), 32'd0);
    OVF_CLR = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
